// File: rtl/umi_arb_pkg.sv
// Shared definitions for the UMI request arbiter: mode encodings and
// width helpers used by the interface, the selector and the top level.
package umi_arb_pkg;

    // Arbitration mode encodings driven on arbmode
    localparam logic UMI_ARB_RR   = 1'b0;
    localparam logic UMI_ARB_PRIO = 1'b1;

    // Width of a starvation counter able to hold the value STARVE
    function automatic int umi_arb_cnt_width(input int starve);
        return $clog2(starve + 32'sd1);
    endfunction

    // Width of a requester index; never narrower than one bit
    function automatic int umi_arb_id_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/umi_arbiter_if.sv
// Bundle of the requester-side and FIFO-side UMI handshake signals of the
// arbiter. The slave modport is the arbiter's view, master is the
// environment's view (requesters plus downstream FIFO).
interface umi_arbiter_if #(
    parameter int N  = 4,
    parameter int UW = 256
);
    import umi_arb_pkg::*;

    localparam int IW = umi_arb_id_width(N);

    logic [N-1:0]    umi_in_valid;
    logic [N*UW-1:0] umi_in_packet;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [UW-1:0]   umi_out_packet;
    logic            umi_out_ready;
    logic [IW-1:0]   grant_id;

    modport slave (
        input  umi_in_valid,
        input  umi_in_packet,
        input  umi_out_ready,
        output umi_in_ready,
        output umi_out_valid,
        output umi_out_packet,
        output grant_id
    );

    modport master (
        output umi_in_valid,
        output umi_in_packet,
        output umi_out_ready,
        input  umi_in_ready,
        input  umi_out_valid,
        input  umi_out_packet,
        input  grant_id
    );

endinterface

// File: rtl/umi_arb_rr.sv
// Combinational winner selection. Round-robin rotates the search to start
// just after the last granted index; priority mode picks the lowest-index
// starved requester if there is one, otherwise the lowest-index valid one.
// Output is one-hot, or zero when nothing is valid.
module umi_arb_rr
    import umi_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    input  logic [N-1:0]  starved,
    input  logic          mode,
    output logic [N-1:0]  grant
);

    logic [N-1:0] rr_grant_s;
    logic [N-1:0] prio_grant_s;
    logic [N-1:0] starve_grant_s;
    logic [N-1:0] starve_elig_s;
    logic         rr_found_s;
    logic         prio_found_s;
    logic         starve_found_s;

    // Rotating search: last+1 ... N-1, 0 ... last; first valid index wins
    always_comb begin
        int idx;
        idx        = 0;
        rr_grant_s = '0;
        rr_found_s = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx             = (int'(last) + i) % N;
            rr_grant_s[idx] = rr_grant_s[idx] | (valid[idx] & ~rr_found_s);
            rr_found_s      = rr_found_s | valid[idx];
        end
    end

    // Fixed priority searches, lowest index first; a stale starved flag on a
    // requester that has just dropped valid must not win, hence the mask
    always_comb begin
        starve_elig_s  = valid & starved;
        prio_grant_s   = '0;
        prio_found_s   = 1'b0;
        starve_grant_s = '0;
        starve_found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            prio_grant_s[i]   = valid[i] & ~prio_found_s;
            prio_found_s      = prio_found_s | valid[i];
            starve_grant_s[i] = starve_elig_s[i] & ~starve_found_s;
            starve_found_s    = starve_found_s | starve_elig_s[i];
        end
    end

    // Pick the result for the requested mode; mode applies the same cycle
    always_comb begin
        grant = '0;
        case (mode)
            UMI_ARB_RR:   grant = rr_grant_s;
            UMI_ARB_PRIO: grant = starve_found_s ? starve_grant_s : prio_grant_s;
            default:      grant = '0;
        endcase
    end

endmodule

// File: rtl/umi_arbiter.sv
// N-to-1 UMI request arbiter in front of a single UMI stream. One requester
// per cycle is moved into a registered output stage; only the granted
// requester sees ready, and only while the output stage can accept.
module umi_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int UW     = 256,
    parameter int STARVE = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arbmode,
    umi_arbiter_if.slave  umi
);

    localparam int              IW       = umi_arb_id_width(N);
    localparam int              CW       = umi_arb_cnt_width(STARVE);
    localparam logic [CW-1:0]   STARVE_C = CW'(STARVE);
    localparam logic [IW-1:0]   LAST_RST = IW'(N - 1);

    // Accept slot and arbitration result
    logic          slot_s;
    logic [N-1:0]  grant_s;
    logic          xfer_s;
    logic [IW-1:0] win_id_s;
    logic [N-1:0]  starved_s;

    // Round-robin pointer
    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;

    // Output stage
    logic          out_valid_q;
    logic          out_valid_d;
    logic [UW-1:0] out_packet_q;
    logic [UW-1:0] out_packet_d;
    logic [IW-1:0] grant_id_q;
    logic [IW-1:0] grant_id_d;

    // Per-requester starvation counters
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // The stage can take a packet when empty or when its packet leaves now
    assign slot_s = ~out_valid_q | umi.umi_out_ready;

    umi_arb_rr #(
        .N  (N),
        .IW (IW)
    ) u_sel (
        .valid   (umi.umi_in_valid),
        .last    (last_q),
        .starved (starved_s),
        .mode    (arbmode),
        .grant   (grant_s)
    );

    // Ready only reaches the winner, and only while the slot is open
    assign umi.umi_in_ready = grant_s & {N{slot_s}};

    // A grant is only ever given to a valid requester, so an open slot with
    // any grant is a transfer
    assign xfer_s = slot_s & (|grant_s);

    // Encode the one-hot grant into an index
    always_comb begin
        win_id_s = '0;
        for (int i = 0; i < N; i++) begin
            win_id_s = win_id_s | (grant_s[i] ? IW'(i) : {IW{1'b0}});
        end
    end

    // Flag requesters whose wait count has saturated
    always_comb begin
        starved_s = '0;
        for (int i = 0; i < N; i++) begin
            starved_s[i] = (cnt_q[i] == STARVE_C);
        end
    end

    // Output stage and pointer: load on transfer, drain when idle, else hold
    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        if (xfer_s) begin
            out_valid_d  = 1'b1;
            out_packet_d = umi.umi_in_packet[int'(win_id_s) * UW +: UW];
            grant_id_d   = win_id_s;
            last_d       = win_id_s;
        end else if (slot_s && umi.umi_out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // Starvation counters: only transfers by others count as waiting, so a
    // downstream stall never pushes a requester towards promotion
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!umi.umi_in_valid[i]) begin
                cnt_d[i] = '0;
            end else if (xfer_s && grant_s[i]) begin
                cnt_d[i] = '0;
            end else if (xfer_s && (cnt_q[i] != STARVE_C)) begin
                cnt_d[i] = cnt_q[i] + CW'(1'b1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Control state with synchronous reset; a held packet is discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            grant_id_q  <= '0;
            last_q      <= LAST_RST;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            grant_id_q  <= grant_id_d;
            last_q      <= last_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Packet data register; qualified by valid so it needs no reset
    always_ff @(posedge clk) begin
        out_packet_q <= out_packet_d;
    end

    assign umi.umi_out_valid  = out_valid_q;
    assign umi.umi_out_packet = out_packet_q;
    assign umi.grant_id       = grant_id_q;

endmodule

// File: tb/tb_umi_arbiter.sv
// Bench for umi_arbiter: N=4, STARVE=15, 32-bit packets. Each requester
// presents a packet tagged with its index and a per-requester sequence
// number that advances only on its own handshake. Expected (id, packet)
// pairs are queued as each scenario drives a grant and checked when the
// output stage hands a packet downstream.
module tb_umi_arbiter;

    localparam int N      = 4;
    localparam int UW     = 32;
    localparam int STARVE = 15;

    typedef struct {
        int            id;
        logic [UW-1:0] pkt;
    } exp_t;

    logic clk;
    logic reset;
    logic arbmode;

    umi_arbiter_if #(.N(N), .UW(UW)) bus ();

    umi_arbiter #(
        .N      (N),
        .UW     (UW),
        .STARVE (STARVE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .arbmode (arbmode),
        .umi     (bus)
    );

    exp_t         exp_q[$];
    int           seq [N];
    int           exp_seq [N];
    logic [N-1:0] hs_q;
    int           checks;
    int           passed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [UW-1:0] mkpkt(input int id, input int s);
        return {8'hA5, id[7:0], s[15:0]};
    endfunction

    // Requester model: packet content follows its own handshake count
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.umi_in_packet[i*UW +: UW] = mkpkt(i, seq[i]);
        end
    end

    always @(negedge clk) begin
        hs_q <= bus.umi_in_valid & bus.umi_in_ready;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] === 1'b1) seq[i] <= seq[i] + 1;
        end
    end

    // Scoreboard: every packet leaving the output stage must be the next one expected
    always @(negedge clk) begin
        if (bus.umi_out_valid === 1'b1 && bus.umi_out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got id %0d pkt %h, required no output", bus.grant_id, bus.umi_out_packet);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.grant_id !== e.id[1:0] || bus.umi_out_packet !== e.pkt)
                    $display("FAIL sb_out: got id %0d pkt %h, required id %0d pkt %h",
                             bus.grant_id, bus.umi_out_packet, e.id, e.pkt);
                else
                    passed++;
            end
        end
    end

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = id;
        e.pkt = mkpkt(id, exp_seq[id]);
        exp_seq[id]++;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        arbmode            = 1'b0;
        bus.umi_in_valid   = 4'b0000;
        bus.umi_out_ready  = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.umi_out_valid !== 1'b0 || bus.grant_id !== 2'd0 || bus.umi_in_ready !== 4'b0000)
            $display("FAIL reset_state: got valid %b id %0d ready %b, required 0 0 0000",
                     bus.umi_out_valid, bus.grant_id, bus.umi_in_ready);
        else passed++;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_rr_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        arbmode           = 1'b0;
        bus.umi_out_ready = 1'b1;
        bus.umi_in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.umi_in_ready !== 4'(1 << order[k]))
                $display("FAIL rr_grant[%0d]: got %b, required %b", k, bus.umi_in_ready, 4'(1 << order[k]));
            else passed++;
            if (k > 0) begin
                checks++;
                if (bus.umi_out_valid !== 1'b1 || bus.grant_id !== 2'(order[k-1]))
                    $display("FAIL rr_latency[%0d]: got valid %b id %0d, required 1 %0d",
                             k, bus.umi_out_valid, bus.grant_id, order[k-1]);
                else passed++;
            end
            push_exp(order[k]);
            next_cycle();
        end
        bus.umi_in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.umi_out_valid !== 1'b1 || bus.grant_id !== 2'd0)
            $display("FAIL rr_last_out: got valid %b id %0d, required 1 0", bus.umi_out_valid, bus.grant_id);
        else passed++;
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.umi_out_valid !== 1'b0)
            $display("FAIL rr_drain: got valid %b, required 0", bus.umi_out_valid);
        else passed++;
        next_cycle();
    endtask

    task automatic test_stall();
        arbmode           = 1'b0;
        bus.umi_out_ready = 1'b0;
        bus.umi_in_valid  = 4'b0110;
        @(negedge clk);
        checks++;
        if (bus.umi_in_ready !== 4'b0010)
            $display("FAIL stall_first: got %b, required 0010", bus.umi_in_ready);
        else passed++;
        push_exp(1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.umi_in_ready !== 4'b0000 || bus.umi_out_valid !== 1'b1 || bus.grant_id !== 2'd1 ||
                bus.umi_out_packet !== mkpkt(1, exp_seq[1] - 1))
                $display("FAIL stall_hold[%0d]: got ready %b valid %b id %0d pkt %h, required 0000 1 1 %h",
                         k, bus.umi_in_ready, bus.umi_out_valid, bus.grant_id, bus.umi_out_packet,
                         mkpkt(1, exp_seq[1] - 1));
            else passed++;
            next_cycle();
        end
        bus.umi_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.umi_in_ready !== 4'b0100)
            $display("FAIL stall_release: got %b, required 0100", bus.umi_in_ready);
        else passed++;
        push_exp(2);
        next_cycle();
        bus.umi_in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.grant_id !== 2'd2)
            $display("FAIL stall_next_id: got %0d, required 2", bus.grant_id);
        else passed++;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_starvation();
        int w;
        arbmode           = 1'b1;
        bus.umi_out_ready = 1'b1;
        bus.umi_in_valid  = 4'b1001;
        for (int k = 0; k < 19; k++) begin
            w = (k == 15) ? 3 : 0;
            @(negedge clk);
            checks++;
            if (bus.umi_in_ready !== 4'(1 << w))
                $display("FAIL starve_grant[%0d]: got %b, required %b", k, bus.umi_in_ready, 4'(1 << w));
            else passed++;
            push_exp(w);
            next_cycle();
        end
        bus.umi_in_valid = 4'b0000;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_wrap();
        int order [4] = '{0, 3, 0, 3};
        arbmode           = 1'b0;
        bus.umi_out_ready = 1'b1;
        bus.umi_in_valid  = 4'b1000;
        @(negedge clk);
        checks++;
        if (bus.umi_in_ready !== 4'b1000)
            $display("FAIL wrap_setup: got %b, required 1000", bus.umi_in_ready);
        else passed++;
        push_exp(3);
        next_cycle();
        bus.umi_in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.umi_in_ready !== 4'(1 << order[k]))
                $display("FAIL wrap_grant[%0d]: got %b, required %b", k, bus.umi_in_ready, 4'(1 << order[k]));
            else passed++;
            push_exp(order[k]);
            next_cycle();
        end
        bus.umi_in_valid = 4'b0000;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        arbmode           = 1'b0;
        bus.umi_out_ready = 1'b0;
        bus.umi_in_valid  = 4'b0010;
        @(negedge clk);
        push_exp(1);
        next_cycle();
        bus.umi_in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.umi_out_valid !== 1'b1 || bus.grant_id !== 2'd1)
            $display("FAIL rstmid_loaded: got valid %b id %0d, required 1 1", bus.umi_out_valid, bus.grant_id);
        else passed++;
        next_cycle();
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.umi_out_valid !== 1'b0 || bus.grant_id !== 2'd0)
            $display("FAIL rstmid_clear: got valid %b id %0d, required 0 0", bus.umi_out_valid, bus.grant_id);
        else passed++;
        next_cycle();
        reset             = 1'b0;
        bus.umi_out_ready = 1'b1;
        bus.umi_in_valid  = 4'b1111;
        @(negedge clk);
        checks++;
        if (bus.umi_in_ready !== 4'b0001)
            $display("FAIL rstmid_first: got %b, required 0001", bus.umi_in_ready);
        else passed++;
        push_exp(0);
        next_cycle();
        bus.umi_in_valid = 4'b0000;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_mode_switch();
        arbmode           = 1'b1;
        bus.umi_out_ready = 1'b1;
        bus.umi_in_valid  = 4'b0011;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checks++;
            if (bus.umi_in_ready !== 4'b0001)
                $display("FAIL switch_build[%0d]: got %b, required 0001", k, bus.umi_in_ready);
            else passed++;
            push_exp(0);
            next_cycle();
        end
        bus.umi_out_ready = 1'b0;
        arbmode           = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.umi_in_ready !== 4'b0000)
                $display("FAIL switch_stall[%0d]: got %b, required 0000", k, bus.umi_in_ready);
            else passed++;
            next_cycle();
        end
        arbmode           = 1'b1;
        bus.umi_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.umi_in_ready !== 4'b0010)
            $display("FAIL switch_starved: got %b, required 0010", bus.umi_in_ready);
        else passed++;
        push_exp(1);
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.umi_in_ready !== 4'b0001)
            $display("FAIL switch_resume: got %b, required 0001", bus.umi_in_ready);
        else passed++;
        push_exp(0);
        next_cycle();
        bus.umi_in_valid = 4'b0000;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        for (int i = 0; i < N; i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        reset             = 1'b1;
        arbmode           = 1'b0;
        bus.umi_in_valid  = 4'b0000;
        bus.umi_out_ready = 1'b0;

        test_reset();
        test_rr_rotation();
        test_stall();
        test_starvation();
        test_wrap();
        test_reset_mid();
        test_mode_switch();

        checks++;
        if (exp_q.size() != 0)
            $display("FAIL sb_leftover: got %0d outstanding packets, required 0", exp_q.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
